// File: rtl/gen_pkg.sv
// Shared definitions for the gen arithmetic block: operation codes and widths.
package gen_pkg;

    // Operation encoding for the elaboration-time 'op' parameter
    localparam int OP_SUB     = 0;
    localparam int OP_ADD     = 1;
    localparam int OP_ABSDIFF = 2;
    localparam int OP_SATADD  = 3;

    // Operand width and result width (one extra bit for carry/borrow)
    localparam int DW = 8;
    localparam int RW = 9;

    typedef logic [DW-1:0] opnd_t;
    typedef logic [RW-1:0] res_t;

endpackage

// File: rtl/gen_addsub.sv
// Combinational 9-bit add/subtract core built as an explicit ripple
// carry/borrow chain. Operands are zero-extended to 9 bits; subtraction is
// A + ~B + 1, so bit 8 of the result is the carry on add and the borrow
// (A < B) on subtract.
module gen_addsub
    import gen_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_sub,
    output logic [RW-1:0] o_sum
);

    logic [RW-1:0] w_x;
    logic [RW-1:0] w_y;
    logic          w_carry;

    assign w_x = {1'b0, i_a};
    assign w_y = {1'b0, i_b} ^ {RW{i_sub}};

    // Ripple chain; carry-in of 1 on subtract completes the two's complement of B
    always_comb begin
        w_carry = i_sub;
        o_sum   = '0;
        for (int k = 0; k < RW; k++) begin
            o_sum[k] = w_x[k] ^ w_y[k] ^ w_carry;
            w_carry  = (w_x[k] & w_y[k]) | (w_carry & (w_x[k] ^ w_y[k]));
        end
    end

endmodule

// File: rtl/gen.sv
// gen: one-cycle registered arithmetic unit. The operation is chosen per
// instance by 'op' and only that datapath is elaborated; all variants share
// the gen_addsub ripple core. cout clears asynchronously while rst_n is low.
module gen
    import gen_pkg::*;
#(
    parameter int op = OP_ADD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] cout
);

    logic [RW-1:0] w_res;
    logic [RW-1:0] r_cout;

    // Clamp a 9-bit unsigned sum to the 8-bit range when the carry is set
    function automatic logic [RW-1:0] f_sat_u8(input logic [RW-1:0] s);
        return s[RW-1] ? {1'b0, {DW{1'b1}}} : s;
    endfunction

    if (op == OP_ADD) begin : g_add
        gen_addsub u_addsub (
            .i_a   (a),
            .i_b   (b),
            .i_sub (1'b0),
            .o_sum (w_res)
        );
    end else if (op == OP_SUB) begin : g_sub
        gen_addsub u_addsub (
            .i_a   (a),
            .i_b   (b),
            .i_sub (1'b1),
            .o_sum (w_res)
        );
    end else if (op == OP_ABSDIFF) begin : g_absdiff
        logic          w_swap;
        logic [DW-1:0] w_hi;
        logic [DW-1:0] w_lo;
        // Put the larger operand first so the difference never borrows
        assign w_swap = (a < b);
        assign w_hi   = w_swap ? b : a;
        assign w_lo   = w_swap ? a : b;
        gen_addsub u_addsub (
            .i_a   (w_hi),
            .i_b   (w_lo),
            .i_sub (1'b1),
            .o_sum (w_res)
        );
    end else if (op == OP_SATADD) begin : g_satadd
        logic [RW-1:0] w_sum;
        gen_addsub u_addsub (
            .i_a   (a),
            .i_b   (b),
            .i_sub (1'b0),
            .o_sum (w_sum)
        );
        assign w_res = f_sat_u8(w_sum);
    end else begin : g_bad_op
        $error("gen: parameter op must be 0..3, got %0d", op);
    end

    // Single output register; async clear, result captured every rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout <= '0;
        end else begin
            r_cout <= w_res;
        end
    end

    assign cout = r_cout;

endmodule

// File: tb/tb_gen.sv
// Bench for gen: four instances (one per op) share the same operands.
// Operands move on a 10 ns grid against a 6 ns clock; a reference model built
// from plain integer arithmetic predicts every registered output.
`timescale 1ns/1ps
module tb_gen;
    import gen_pkg::*;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] c_sub, c_add, c_abs, c_sat;
    logic [RW-1:0] c_all [4];

    int n_checks = 0;
    int n_errors = 0;

    gen #(.op(OP_SUB))     u_sub (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cout(c_sub));
    gen #(.op(OP_ADD))     u_add (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cout(c_add));
    gen #(.op(OP_ABSDIFF)) u_abs (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cout(c_abs));
    gen #(.op(OP_SATADD))  u_sat (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cout(c_sat));

    assign c_all[0] = c_sub;
    assign c_all[1] = c_add;
    assign c_all[2] = c_abs;
    assign c_all[3] = c_sat;

    initial clk = 1'b0;
    always #3 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference behaviour of each operation on plain integers
    function automatic int model(input int opc, input int x, input int y);
        case (opc)
            0:       return (x - y + 512) % 512;
            1:       return x + y;
            2:       return (x > y) ? x - y : y - x;
            default: return (x + y > 255) ? 255 : x + y;
        endcase
    endfunction

    // Expected outputs tracked per clock; cleared immediately by reset
    logic [RW-1:0] exp_c [4];
    bit primed = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) exp_c[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) exp_c[k] <= 9'(model(k, int'(a), int'(b)));
            primed <= 1'b1;
        end
    end

    // Continuous comparison on the falling edge, away from the capture edge
    always @(negedge clk) begin
        if (primed) begin
            chk("model_sub", c_all[0], exp_c[0]);
            chk("model_add", c_all[1], exp_c[1]);
            chk("model_abs", c_all[2], exp_c[2]);
            chk("model_sat", c_all[3], exp_c[3]);
        end
    end

    // Present operands, then sample 1 ns after the capturing edge
    task automatic step(input logic [DW-1:0] na, input logic [DW-1:0] nb);
        a = na;
        b = nb;
        @(posedge clk);
        #1;
    endtask

    // Realign to the 10 ns operand grid
    task automatic gap();
        #(10 - ($time % 10));
    endtask

    task automatic chk_all(input string tag, input int x, input int y);
        chk({tag, "_sub"}, c_sub, 9'(model(0, x, y)));
        chk({tag, "_add"}, c_add, 9'(model(1, x, y)));
        chk({tag, "_abs"}, c_abs, 9'(model(2, x, y)));
        chk({tag, "_sat"}, c_sat, 9'(model(3, x, y)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ra, rb;
        rst_n = 1'b0;
        a = 8'd0;
        b = 8'd0;
        #1;
        chk("rst_sub", c_sub, 9'h000);
        chk("rst_add", c_add, 9'h000);
        chk("rst_abs", c_abs, 9'h000);
        chk("rst_sat", c_sat, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        gap();

        step(8'd0, 8'd0);
        chk("zero_sub", c_sub, 9'd0);
        chk("zero_add", c_add, 9'd0);
        chk("zero_abs", c_abs, 9'd0);
        chk("zero_sat", c_sat, 9'd0);
        gap();

        step(8'd3, 8'd2);
        chk("s1_add", c_add, 9'd5);
        chk("s1_sub", c_sub, 9'd1);
        gap();

        step(8'd10, 8'd4);
        chk("s2_add", c_add, 9'd14);
        chk("s2_sub", c_sub, 9'd6);
        gap();

        step(8'd3, 8'd10);
        chk("s3_sub", c_sub, 9'h1F9);
        chk("s3_abs", c_abs, 9'd7);
        chk("s3_add", c_add, 9'd13);
        chk("s3_sat", c_sat, 9'd13);
        gap();

        step(8'd255, 8'd255);
        chk("max_add", c_add, 9'd510);
        chk("max_sat", c_sat, 9'd255);
        chk("max_sub", c_sub, 9'd0);
        chk("max_abs", c_abs, 9'd0);
        gap();

        step(8'd0, 8'd255);
        chk("borrow_sub", c_sub, 9'h101);
        chk("borrow_abs", c_abs, 9'd255);
        gap();

        step(8'd200, 8'd100);
        chk("sat_clamp", c_sat, 9'd255);
        chk("sat_add", c_add, 9'd300);
        gap();

        for (int i = 1; i <= 99; i++) begin
            step(8'(i + 10), 8'(i + 3));
            chk("sweep_add", c_add, 9'(2 * i + 13));
            chk("sweep_sub", c_sub, 9'd7);
            if (i == 50) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_sub", c_sub, 9'd0);
                chk("midrst_add", c_add, 9'd0);
                chk("midrst_abs", c_abs, 9'd0);
                chk("midrst_sat", c_sat, 9'd0);
                @(posedge clk);
                #1;
                chk("midrst_hold", c_add, 9'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk("release_add", c_add, 9'(2 * i + 13));
                chk("release_sub", c_sub, 9'd7);
            end
            gap();
        end

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 0;
                1:       ra = 255;
                default: ra = int'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 3))
                0:       rb = 0;
                1:       rb = 255;
                default: rb = int'($urandom_range(0, 255));
            endcase
            step(8'(ra), 8'(rb));
            chk_all("rand", ra, rb);
            gap();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gen.md
GEN -- requirements
Module: gen

Interface
REQ-001 Parameter op, default 1, selects the operation at elaboration: 1 = add, 0 = subtract, 2 = absolute difference, 3 = saturating add.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 a  input  8  unsigned operand A.
REQ-005 b  input  8  unsigned operand B.
REQ-006 cout  output  9  registered result of the selected operation.

Function
REQ-007 Operation shall be fixed per instance by op through a generate construct; only the selected datapath shall be built.
REQ-008 Any op value outside 0..3 shall stop elaboration with an error.
REQ-009 Latency shall be exactly one clock: cout after rising edge N reflects a and b sampled at edge N.
REQ-010 cout shall hold its value between rising edges, with no combinational path from a/b to cout.
REQ-011 op=1: cout = a + b, zero-extended to 9 bits; cout[8] is the carry-out (range 0..510).
REQ-012 op=0: cout = {1'b0,a} - {1'b0,b} modulo 2^9, i.e. the 9-bit two's-complement difference; cout[8]=1 exactly when a < b (borrow).
REQ-013 op=2: cout = |a - b|, zero-extended; cout[8] always 0.
REQ-014 op=3: cout = min(a + b, 255), zero-extended; cout[8] always 0.
REQ-015 Boundaries (outputs are one clock later per REQ-009):
- a=b=0 gives cout=0 for every op.
- a=b=255: op1 -> 510, op0 -> 0, op2 -> 0, op3 -> 255.
- a=0,b=255, op0 -> 9'h101.
REQ-016 a and b shall be treated as synchronous to clk; no X-propagation suppression is required.

Reset
REQ-017 While rst_n=0, cout shall be 9'h000 immediately, independent of clk.
REQ-018 Deassertion of rst_n shall be synchronous to clk.
REQ-019 After deassertion, the first rising edge shall register a valid result.
REQ-020 Asserting reset mid-stream shall discard the in-flight result; no stale value shall appear after release.

Structure
REQ-021 A shared package gen_pkg shall hold:
- op encoding constants: OP_SUB=0, OP_ADD=1, OP_ABSDIFF=2, OP_SATADD=3;
- width constants: DW=8, RW=9.
REQ-022 One sub-module, gen_addsub, shall implement the combinational 9-bit add/subtract core with a sub control input and an explicit carry/borrow chain.
REQ-023 op=1, op=0 and op=2 shall reuse gen_addsub; op=2 adds a compare-and-swap of the operands ahead of it.
REQ-024 op=3 shall reuse the adder and clamp on carry.
REQ-025 gen shall contain the generate selection plus a single output register.

Verification
REQ-026 Bench clock period shall be 6 ns, with operand changes every 10 ns (asynchronous to the clock edges). Two instances (op=1 and op=0) shall be driven from the same a/b.
REQ-027 Scenario: a=3,b=2 -> next edge op1 cout=5, op0 cout=1.
REQ-028 Scenario: a=10,b=4 -> op1 cout=14, op0 cout=6.
REQ-029 Scenario: a=3,b=10 -> op0 cout=9'h1F9, op2 cout=7, op1 cout=13.
REQ-030 Scenario: a=255,b=255 -> op1 cout=510, op3 cout=255, op0 cout=0.
REQ-031 Scenario: sweep a=i+10, b=i+3 for i=1..99 -> op1 cout=2i+13, op0 cout=7 each cycle after capture.
REQ-032 Scenario: assert rst_n=0 mid-sweep -> cout=0 at once without a clock edge; after release the first edge restores the correct result.
